// File: rtl/mem_writeback_pkg.sv
// ============================================================================
// mem_writeback_pkg : shared control-bit positions, widths and FSM encoding
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_writeback_pkg;

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned REG_W    = 5;
   localparam int unsigned CTR_M_W  = 3;
   localparam int unsigned CTR_WB_W = 2;

   localparam int unsigned M_MEMWRITE  = 0;
   localparam int unsigned M_MEMREAD   = 1;
   localparam int unsigned M_BRANCH    = 2;
   localparam int unsigned WB_MEMTOREG = 0;
   localparam int unsigned WB_REGWRITE = 1;

   localparam int unsigned STATE_W = 1;
   typedef logic [STATE_W-1:0] state_t;
   localparam state_t S_IDLE = 1'b0;
   localparam state_t S_WAIT = 1'b1;

   // Word-aligned and inside the DEPTH-word data memory.
   function automatic logic addr_valid(input logic [DATA_W-1:0] addr,
                                       input int unsigned depth);
      return (addr[1:0] == 2'b00) && ({1'b0, addr} < 33'(4 * depth));
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_writeback_if.sv
// ============================================================================
// mem_writeback_if : EX/MEM pipeline inputs and MEM/WB result bundle
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_writeback_if;
   import mem_writeback_pkg::*;

   logic [CTR_M_W-1:0]  ex_ctr_m;
   logic [CTR_WB_W-1:0] ex_ctr_wb;
   logic [DATA_W-1:0]   ex_alu_result;
   logic                ex_zero;
   logic [DATA_W-1:0]   ex_store_data;
   logic [REG_W-1:0]    ex_dest_reg;
   logic [DATA_W-1:0]   ex_branch_target;

   logic                mem_stall;
   logic                regwrite_flag;
   logic [REG_W-1:0]    write_reg;
   logic [DATA_W-1:0]   write_data;
   logic                pc_src;
   logic [DATA_W-1:0]   branch_target;
   logic                addr_err;

   modport master (
      output ex_ctr_m, ex_ctr_wb, ex_alu_result, ex_zero, ex_store_data,
             ex_dest_reg, ex_branch_target,
      input  mem_stall, regwrite_flag, write_reg, write_data, pc_src,
             branch_target, addr_err
   );

   modport slave (
      input  ex_ctr_m, ex_ctr_wb, ex_alu_result, ex_zero, ex_store_data,
             ex_dest_reg, ex_branch_target,
      output mem_stall, regwrite_flag, write_reg, write_data, pc_src,
             branch_target, addr_err
   );

endinterface

`default_nettype wire

// File: rtl/mem_writeback_data_mem.sv
// ============================================================================
// data_mem : word-addressed data memory, synchronous write, async read,
//            synchronous clear of every word on reset
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem
   import mem_writeback_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] rd_words [DEPTH];

   generate
      for (genvar i = 0; i < DEPTH; i++) begin : g_word
         logic [DATA_W-1:0] word_d;
         logic [DATA_W-1:0] word_q;

         always_comb begin
            word_d = word_q;
            if (we && (waddr == AW'(i))) begin
               word_d = wdata;
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               word_q <= '0;
            end else begin
               word_q <= word_d;
            end
         end

         assign rd_words[i] = word_q;
      end
   endgenerate

   assign rdata = rd_words[raddr];

endmodule

`default_nettype wire

// File: rtl/mem_writeback.sv
// ============================================================================
// mem_writeback : MEM/WB pipeline stage with a fixed-latency stalling data
//                 memory, register writeback and taken-branch redirect
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_writeback
   import mem_writeback_pkg::*;
#(
   parameter int DEPTH       = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic           clk,
   input  logic           rst,
   mem_writeback_if.slave bus
);

   localparam int         AW       = $clog2(DEPTH);
   localparam logic       HAS_WAIT = (WAIT_CYCLES != 0);
   localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   state_t            state_d, state_q;
   logic [3:0]        cnt_d, cnt_q;
   logic              mem_stall;
   logic              complete;

   logic              is_store;
   logic              is_access;
   logic              addr_ok;
   logic [AW-1:0]     word_idx;
   logic [DATA_W-1:0] mem_rdata;
   logic [DATA_W-1:0] load_data;
   logic              mem_we;

   logic              regwrite_flag_d, regwrite_flag_q;
   logic [REG_W-1:0]  write_reg_d, write_reg_q;
   logic [DATA_W-1:0] write_data_d, write_data_q;
   logic              pc_src_d, pc_src_q;
   logic [DATA_W-1:0] branch_target_d, branch_target_q;
   logic              addr_err_d, addr_err_q;

   // memwrite wins when both memwrite and memread are set
   assign is_store  = bus.ex_ctr_m[M_MEMWRITE];
   assign is_access = is_store | bus.ex_ctr_m[M_MEMREAD];
   assign addr_ok   = addr_valid(bus.ex_alu_result, DEPTH);
   assign word_idx  = bus.ex_alu_result[AW+1:2];
   assign load_data = addr_ok ? mem_rdata : '0;
   assign mem_we    = complete & is_store & addr_ok;

   data_mem #(
      .DEPTH (DEPTH)
   ) u_data_mem (
      .clk   (clk),
      .rst   (rst),
      .we    (mem_we),
      .waddr (word_idx),
      .wdata (bus.ex_store_data),
      .raddr (word_idx),
      .rdata (mem_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (is_access && HAS_WAIT) begin
               state_d = S_WAIT;
               cnt_d   = CNT_INIT;
            end
         end
         S_WAIT: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      mem_stall = 1'b0;
      complete  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (is_access && HAS_WAIT) begin
               mem_stall = 1'b1;
            end else begin
               complete  = 1'b1;
            end
         end
         S_WAIT: begin
            if (cnt_q != 4'd0) begin
               mem_stall = 1'b1;
            end else begin
               complete  = 1'b1;
            end
         end
         default: mem_stall = 1'b0;
      endcase
   end

   // Stall edges load a bubble; only the data/target registers hold.
   always_comb begin
      regwrite_flag_d = 1'b0;
      pc_src_d        = 1'b0;
      addr_err_d      = 1'b0;
      write_reg_d     = write_reg_q;
      write_data_d    = write_data_q;
      branch_target_d = branch_target_q;
      if (complete) begin
         regwrite_flag_d = bus.ex_ctr_wb[WB_REGWRITE] && (bus.ex_dest_reg != '0);
         write_reg_d     = bus.ex_dest_reg;
         write_data_d    = bus.ex_ctr_wb[WB_MEMTOREG] ? load_data : bus.ex_alu_result;
         pc_src_d        = bus.ex_ctr_m[M_BRANCH] && bus.ex_zero;
         branch_target_d = bus.ex_branch_target;
         addr_err_d      = is_access && !addr_ok;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         regwrite_flag_q <= 1'b0;
         write_reg_q     <= '0;
         write_data_q    <= '0;
         pc_src_q        <= 1'b0;
         branch_target_q <= '0;
         addr_err_q      <= 1'b0;
      end else begin
         regwrite_flag_q <= regwrite_flag_d;
         write_reg_q     <= write_reg_d;
         write_data_q    <= write_data_d;
         pc_src_q        <= pc_src_d;
         branch_target_q <= branch_target_d;
         addr_err_q      <= addr_err_d;
      end
   end

   assign bus.mem_stall     = mem_stall;
   assign bus.regwrite_flag = regwrite_flag_q;
   assign bus.write_reg     = write_reg_q;
   assign bus.write_data    = write_data_q;
   assign bus.pc_src        = pc_src_q;
   assign bus.branch_target = branch_target_q;
   assign bus.addr_err      = addr_err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_writeback.sv
// ============================================================================
// tb_mem_writeback : directed stimulus with a queue-based result scoreboard
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_writeback;
   import mem_writeback_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_writeback_if bus ();

   mem_writeback #(
      .DEPTH       (64),
      .WAIT_CYCLES (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      string       name;
      logic        rf;
      logic [4:0]  wr;
      logic [31:0] wd;
      logic        pc;
      logic [31:0] bt;
      logic        ae;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic        pending  = 1'b0;
   logic [4:0]  prev_wr  = '0;
   logic [31:0] prev_wd  = '0;
   logic [31:0] prev_bt  = '0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
      end
   endtask

   task automatic drive(input logic [2:0] m, input logic [1:0] wb, input logic [31:0] alu,
                        input logic z, input logic [31:0] sd, input logic [4:0] d,
                        input logic [31:0] bt);
      bus.ex_ctr_m         = m;
      bus.ex_ctr_wb        = wb;
      bus.ex_alu_result    = alu;
      bus.ex_zero          = z;
      bus.ex_store_data    = sd;
      bus.ex_dest_reg      = d;
      bus.ex_branch_target = bt;
   endtask

   // Presents one instruction, holds it through the stall, checks the bubble.
   task automatic issue(input string name, input logic [2:0] m, input logic [1:0] wb,
                        input logic [31:0] alu, input logic z, input logic [31:0] sd,
                        input logic [4:0] d, input logic [31:0] bt, input int exp_stall,
                        input logic erf, input logic [31:0] ewd, input logic epc,
                        input logic eae);
      exp_t e;
      int   stalls = 0;
      bit   done   = 1'b0;
      drive(m, wb, alu, z, sd, d, bt);
      e.name = name; e.rf = erf; e.wr = d; e.wd = ewd; e.pc = epc; e.bt = bt; e.ae = eae;
      exp_q.push_back(e);
      for (int k = 0; k < 16 && !done; k++) begin
         @(negedge clk);
         if (k > 0) begin
            check({name, ".bubble"}, {61'd0, bus.regwrite_flag, bus.pc_src, bus.addr_err}, 64'd0);
            check({name, ".hold_wd"}, {32'd0, bus.write_data}, {32'd0, prev_wd});
            check({name, ".hold_wr_bt"}, {27'd0, bus.write_reg, bus.branch_target},
                  {27'd0, prev_wr, prev_bt});
         end
         if (!bus.mem_stall) done = 1'b1;
         else stalls++;
      end
      check({name, ".stall_cycles"}, 64'(stalls), 64'(exp_stall));
      @(posedge clk); #1;
      prev_wr = d; prev_wd = ewd; prev_bt = bt;
   endtask

   // Scoreboard monitor: one expected entry per completion edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (pending) begin
            if (exp_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_completion: got a completion, expected none queued");
            end else begin
               e = exp_q.pop_front();
               check({e.name, ".regwrite_flag"}, {63'd0, bus.regwrite_flag}, {63'd0, e.rf});
               check({e.name, ".write_reg"},     {59'd0, bus.write_reg},     {59'd0, e.wr});
               check({e.name, ".write_data"},    {32'd0, bus.write_data},    {32'd0, e.wd});
               check({e.name, ".pc_src"},        {63'd0, bus.pc_src},        {63'd0, e.pc});
               check({e.name, ".branch_target"}, {32'd0, bus.branch_target}, {32'd0, e.bt});
               check({e.name, ".addr_err"},      {63'd0, bus.addr_err},      {63'd0, e.ae});
            end
         end
         pending = !rst && !bus.mem_stall;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1, "watchdog expired");
   end

   task automatic check_all_zero(input string name);
      check({name, ".outputs"}, {57'd0, bus.regwrite_flag, bus.write_reg, bus.pc_src, bus.addr_err},
            64'd0);
      check({name, ".data_target"}, {bus.write_data, bus.branch_target}, 64'd0);
      check({name, ".mem_stall"}, {63'd0, bus.mem_stall}, 64'd0);
   endtask

   initial begin
      drive(3'b000, 2'b00, 32'h0, 1'b0, 32'h0, 5'd0, 32'h0);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;

      //     name        m       wb     alu           z     store data    d     target      st erf  exp wdata    epc  eae
      issue("st_8",     3'b001, 2'b00, 32'h0000_0008, 1'b0, 32'hDEADBEEF, 5'd0, 32'h0,      2, 1'b0, 32'h8,        1'b0, 1'b0);
      issue("ld_8",     3'b010, 2'b11, 32'h0000_0008, 1'b0, 32'h0,        5'd5, 32'h0,      2, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
      issue("rtype",    3'b000, 2'b10, 32'h0000_0023, 1'b0, 32'h0,        5'd4, 32'h0,      0, 1'b1, 32'h23,       1'b0, 1'b0);
      issue("beq_t",    3'b100, 2'b00, 32'h0,         1'b1, 32'h0,        5'd0, 32'h40,     0, 1'b0, 32'h0,        1'b1, 1'b0);
      issue("beq_nt",   3'b100, 2'b00, 32'h0,         1'b0, 32'h0,        5'd0, 32'h80,     0, 1'b0, 32'h0,        1'b0, 1'b0);
      issue("ld_mis6",  3'b010, 2'b11, 32'h0000_0006, 1'b0, 32'h0,        5'd7, 32'h0,      2, 1'b1, 32'h0,        1'b0, 1'b1);
      issue("ld_misA",  3'b010, 2'b11, 32'h0000_000A, 1'b0, 32'h0,        5'd7, 32'h0,      2, 1'b1, 32'h0,        1'b0, 1'b1);
      issue("st_oob",   3'b001, 2'b00, 32'h0000_0100, 1'b0, 32'h12345678, 5'd0, 32'h0,      2, 1'b0, 32'h100,      1'b0, 1'b1);
      issue("ld_0",     3'b010, 2'b11, 32'h0,         1'b0, 32'h0,        5'd3, 32'h0,      2, 1'b1, 32'h0,        1'b0, 1'b0);
      issue("rt_x0",    3'b000, 2'b10, 32'h0000_0055, 1'b0, 32'h0,        5'd0, 32'h0,      0, 1'b0, 32'h55,       1'b0, 1'b0);
      issue("st_fc",    3'b001, 2'b00, 32'h0000_00FC, 1'b0, 32'hA5A5A5A5, 5'd0, 32'h0,      2, 1'b0, 32'hFC,       1'b0, 1'b0);
      issue("ld_fc",    3'b010, 2'b11, 32'h0000_00FC, 1'b0, 32'h0,        5'd9, 32'h0,      2, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0);
      issue("ld_alu",   3'b010, 2'b10, 32'h0000_0004, 1'b0, 32'h0,        5'd2, 32'h0,      2, 1'b1, 32'h4,        1'b0, 1'b0);
      issue("st_both",  3'b011, 2'b00, 32'h0000_0010, 1'b0, 32'h11112222, 5'd0, 32'h0,      2, 1'b0, 32'h10,       1'b0, 1'b0);
      issue("ld_10",    3'b010, 2'b11, 32'h0000_0010, 1'b0, 32'h0,        5'd6, 32'h0,      2, 1'b1, 32'h11112222, 1'b0, 1'b0);

      // Store abandoned by a reset in its second stall cycle
      drive(3'b001, 2'b00, 32'h0000_000C, 1'b0, 32'hCAFEF00D, 5'd0, 32'h0);
      @(posedge clk); #1;
      rst = 1'b1;
      drive(3'b000, 2'b00, 32'h0, 1'b0, 32'h0, 5'd0, 32'h0);
      @(posedge clk); #1;
      check_all_zero("rst_mid_wait");
      rst = 1'b0;
      prev_wr = '0; prev_wd = '0; prev_bt = '0;

      issue("ld_c_rst", 3'b010, 2'b11, 32'h0000_000C, 1'b0, 32'h0,        5'd1, 32'h0,      2, 1'b1, 32'h0,        1'b0, 1'b0);
      issue("ld_8_rst", 3'b010, 2'b11, 32'h0000_0008, 1'b0, 32'h0,        5'd5, 32'h0,      2, 1'b1, 32'h0,        1'b0, 1'b0);

      rst = 1'b1;
      drive(3'b000, 2'b00, 32'h0, 1'b0, 32'h0, 5'd0, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
